// File: rtl/tlp_tx_arb_16b.sv
// Round-robin arbiter/sequencer sharing the core's 16-bit TLP transmit port among NUM_REQ sources.
// Optional grant-to-start watchdog is enabled by defining TX_ARB_WDOG_EN.
module tlp_tx_arb_16b #(
  parameter int NUM_REQ     = 4,
  parameter int WDOG_CYCLES = 64
) (
  input  logic                   clk_125,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  output logic [NUM_REQ-1:0]     gnt,
  input  logic [16*NUM_REQ-1:0]  src_data,
  input  logic [NUM_REQ-1:0]     src_st,
  input  logic [NUM_REQ-1:0]     src_end,
  output logic                   tx_req,
  input  logic                   tx_rdy,
  output logic [15:0]            tx_data,
  output logic                   tx_st,
  output logic                   tx_end,
  output logic                   busy,
  output logic [1:0]             cur_sel,
  output logic                   err_timeout
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, GNT = 2'd2, XFER = 2'd3} state_t;

  if (NUM_REQ < 2 || NUM_REQ > 4 || WDOG_CYCLES < 2) begin : g_bad_cfg
    $error("tlp_tx_arb_16b: unsupported NUM_REQ or WDOG_CYCLES");
  end

  function automatic logic [1:0] wrap_inc(input logic [1:0] idx);
    if (idx == 2'(NUM_REQ - 1)) begin
      wrap_inc = 2'd0;
    end else begin
      wrap_inc = idx + 2'd1;
    end
  endfunction

  state_t               state_r, next_state_s;
  logic [1:0]           ptr_r, next_ptr_s;
  logic [1:0]           sel_r, next_sel_s;
  logic [1:0]           pick_s;
  logic                 pick_vld_s;
  logic                 grant_s;
  logic                 wdog_hit_s;
  logic                 sel_st_s, sel_end_s;
  logic [15:0]          sel_data_s;
  logic [NUM_REQ-1:0]   gnt_r;
  logic                 tx_req_r, tx_st_r, tx_end_r, busy_r;
  logic [15:0]          tx_data_r;

  assign sel_st_s   = src_st[sel_r];
  assign sel_end_s  = src_end[sel_r];
  assign sel_data_s = src_data[{sel_r, 4'd0} +: 16];

  // Round-robin pick: first request at or above ptr, wrapping modulo NUM_REQ.
  always_comb begin : pick
    logic [2:0] sum_v;
    sum_v      = 3'd0;
    pick_s     = 2'd0;
    pick_vld_s = 1'b0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      sum_v = {1'b0, ptr_r} + 3'(j);
      if (sum_v >= 3'(NUM_REQ)) begin
        sum_v = sum_v - 3'(NUM_REQ);
      end else begin
        sum_v = sum_v;
      end
      if (req[sum_v[1:0]]) begin
        pick_s     = sum_v[1:0];
        pick_vld_s = 1'b1;
      end else begin
        pick_s     = pick_s;
        pick_vld_s = pick_vld_s;
      end
    end
  end

  // Next-state logic for the request/grant/transfer sequence.
  always_comb begin
    next_state_s = state_r;
    next_ptr_s   = ptr_r;
    next_sel_s   = sel_r;
    grant_s      = 1'b0;
    case (state_r)
      IDLE: begin
        if (pick_vld_s) begin
          next_sel_s   = pick_s;
          next_state_s = REQ;
        end else begin
          next_state_s = IDLE;
        end
      end
      REQ: begin
        if (tx_rdy) begin
          grant_s      = 1'b1;
          next_state_s = GNT;
        end else begin
          next_state_s = REQ;
        end
      end
      GNT: begin
        if (sel_st_s && sel_end_s) begin
          next_state_s = IDLE;
          next_ptr_s   = wrap_inc(sel_r);
        end else if (sel_st_s) begin
          next_state_s = XFER;
        end else if (wdog_hit_s) begin
          next_state_s = IDLE;
          next_ptr_s   = wrap_inc(sel_r);
        end else begin
          next_state_s = GNT;
        end
      end
      XFER: begin
        if (sel_end_s) begin
          next_state_s = IDLE;
          next_ptr_s   = wrap_inc(sel_r);
        end else begin
          next_state_s = XFER;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // State, arbitration bookkeeping and registered outputs.
  always_ff @(posedge clk_125) begin
    if (rst) begin
      state_r   <= IDLE;
      ptr_r     <= 2'd0;
      sel_r     <= 2'd0;
      gnt_r     <= {NUM_REQ{1'b0}};
      tx_req_r  <= 1'b0;
      busy_r    <= 1'b0;
      tx_data_r <= 16'd0;
      tx_st_r   <= 1'b0;
      tx_end_r  <= 1'b0;
    end else begin
      state_r  <= next_state_s;
      ptr_r    <= next_ptr_s;
      sel_r    <= next_sel_s;
      tx_req_r <= (next_state_s == REQ);
      busy_r   <= (next_state_s != IDLE);
      gnt_r    <= {NUM_REQ{1'b0}};
      if (grant_s) begin
        gnt_r[sel_r] <= 1'b1;
      end
      // Only the selected source reaches the core, and only while it owns the port.
      if (state_r == GNT || state_r == XFER) begin
        tx_data_r <= sel_data_s;
        tx_st_r   <= sel_st_s;
        tx_end_r  <= sel_end_s;
      end else begin
        tx_data_r <= 16'd0;
        tx_st_r   <= 1'b0;
        tx_end_r  <= 1'b0;
      end
    end
  end

`ifdef TX_ARB_WDOG_EN
  localparam int CW = $clog2(WDOG_CYCLES);
  logic [CW-1:0] wdog_cnt_r;
  logic          err_timeout_r;

  assign wdog_hit_s = (state_r == GNT) && (wdog_cnt_r == CW'(WDOG_CYCLES - 1));

  // Grant-to-start watchdog: counts cycles spent in GNT, zero on entry.
  always_ff @(posedge clk_125) begin
    if (rst) begin
      wdog_cnt_r    <= {CW{1'b0}};
      err_timeout_r <= 1'b0;
    end else begin
      if (state_r == GNT) begin
        wdog_cnt_r <= wdog_cnt_r + CW'(1);
      end else begin
        wdog_cnt_r <= {CW{1'b0}};
      end
      err_timeout_r <= wdog_hit_s && !sel_st_s;
    end
  end

  assign err_timeout = err_timeout_r;
`else
  assign wdog_hit_s  = 1'b0;
  assign err_timeout = 1'b0;
`endif

  assign gnt     = gnt_r;
  assign tx_req  = tx_req_r;
  assign tx_data = tx_data_r;
  assign tx_st   = tx_st_r;
  assign tx_end  = tx_end_r;
  assign busy    = busy_r;
  assign cur_sel = sel_r;

endmodule

// File: tb/tb_tlp_tx_arb_16b.sv
// Directed bench for tlp_tx_arb_16b: vector table for a single-source TLP plus hand-written
// sequences for fairness, foreign strobes, st/end in one beat, reset mid-TLP and the watchdog.
module tb_tlp_tx_arb_16b;

  logic        clk_125 = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  gnt;
  logic [63:0] src_data;
  logic [3:0]  src_st;
  logic [3:0]  src_end;
  logic        tx_req;
  logic        tx_rdy;
  logic [15:0] tx_data;
  logic        tx_st;
  logic        tx_end;
  logic        busy;
  logic [1:0]  cur_sel;
  logic        err_timeout;

  int total = 0;
  int bad   = 0;

  always #4 clk_125 = ~clk_125;

  tlp_tx_arb_16b #(.NUM_REQ(4), .WDOG_CYCLES(8)) dut (
    .clk_125(clk_125), .rst(rst), .req(req), .gnt(gnt), .src_data(src_data),
    .src_st(src_st), .src_end(src_end), .tx_req(tx_req), .tx_rdy(tx_rdy),
    .tx_data(tx_data), .tx_st(tx_st), .tx_end(tx_end), .busy(busy),
    .cur_sel(cur_sel), .err_timeout(err_timeout)
  );

  typedef struct packed {
    logic [3:0]  req;
    logic        rdy;
    logic [3:0]  st;
    logic [3:0]  en;
    logic [15:0] d2;
    logic [25:0] exp;
  } vec_t;

  vec_t vecs [11];

  function automatic logic [25:0] ov(input logic txr, input logic [3:0] g, input logic st,
                                     input logic en, input logic [15:0] d, input logic b,
                                     input logic [1:0] cs);
    return {txr, g, st, en, d, b, cs};
  endfunction

  function automatic logic [25:0] obs();
    return ov(tx_req, gnt, tx_st, tx_end, tx_data, busy, cur_sel);
  endfunction

  function automatic vec_t mk(input logic [3:0] r, input logic y, input logic [3:0] s,
                              input logic [3:0] e, input logic [15:0] d, input logic [25:0] x);
    return {r, y, s, e, d, x};
  endfunction

  task automatic tick();
    @(posedge clk_125);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    req      = 4'b0000;
    tx_rdy   = 1'b0;
    src_st   = 4'b0000;
    src_end  = 4'b0000;
    src_data = {16'h3333, 16'h2222, 16'h1111, 16'h0F0F};
  endtask

  task automatic set_data(input int s, input logic [15:0] d);
    src_data[16*s +: 16] = d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    chk("reset_out", 32'(obs()), 32'd0);
    chk("reset_err", 32'(err_timeout), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    logic [15:0] dexp;
    int          wait_n;
    logic        got;

    // Source 2 alone: tx_rdy after 3 cycles, then 6 beats 0xA000..0xA005.
    vecs[0]  = mk(4'b0100, 1'b0, 4'b0000, 4'b0000, 16'h0000, ov(1'b1, 4'b0000, 1'b0, 1'b0, 16'h0000, 1'b1, 2'd2));
    vecs[1]  = mk(4'b0100, 1'b0, 4'b0000, 4'b0000, 16'h0000, ov(1'b1, 4'b0000, 1'b0, 1'b0, 16'h0000, 1'b1, 2'd2));
    vecs[2]  = mk(4'b0100, 1'b0, 4'b0000, 4'b0000, 16'h0000, ov(1'b1, 4'b0000, 1'b0, 1'b0, 16'h0000, 1'b1, 2'd2));
    vecs[3]  = mk(4'b0100, 1'b1, 4'b0000, 4'b0000, 16'h0000, ov(1'b0, 4'b0100, 1'b0, 1'b0, 16'h0000, 1'b1, 2'd2));
    vecs[4]  = mk(4'b0000, 1'b0, 4'b0100, 4'b0000, 16'hA000, ov(1'b0, 4'b0000, 1'b1, 1'b0, 16'hA000, 1'b1, 2'd2));
    vecs[5]  = mk(4'b0000, 1'b0, 4'b0000, 4'b0000, 16'hA001, ov(1'b0, 4'b0000, 1'b0, 1'b0, 16'hA001, 1'b1, 2'd2));
    vecs[6]  = mk(4'b0000, 1'b0, 4'b0000, 4'b0000, 16'hA002, ov(1'b0, 4'b0000, 1'b0, 1'b0, 16'hA002, 1'b1, 2'd2));
    vecs[7]  = mk(4'b0000, 1'b0, 4'b0000, 4'b0000, 16'hA003, ov(1'b0, 4'b0000, 1'b0, 1'b0, 16'hA003, 1'b1, 2'd2));
    vecs[8]  = mk(4'b0000, 1'b0, 4'b0000, 4'b0000, 16'hA004, ov(1'b0, 4'b0000, 1'b0, 1'b0, 16'hA004, 1'b1, 2'd2));
    vecs[9]  = mk(4'b0000, 1'b0, 4'b0000, 4'b0100, 16'hA005, ov(1'b0, 4'b0000, 1'b0, 1'b1, 16'hA005, 1'b0, 2'd2));
    vecs[10] = mk(4'b0000, 1'b0, 4'b0000, 4'b0000, 16'h0000, ov(1'b0, 4'b0000, 1'b0, 1'b0, 16'h0000, 1'b0, 2'd2));

    do_reset();
    for (int k = 0; k < 11; k++) begin
      req      = vecs[k].req;
      tx_rdy   = vecs[k].rdy;
      src_st   = vecs[k].st;
      src_end  = vecs[k].en;
      set_data(2, vecs[k].d2);
      tick();
      chk($sformatf("single[%0d]", k), 32'(obs()), 32'(vecs[k].exp));
    end

    // All four requesting continuously: 8 TLPs of 4 beats, order 0,1,2,3,0,1,2,3.
    do_reset();
    req    = 4'b1111;
    tx_rdy = 1'b1;
    for (int t = 0; t < 8; t++) begin
      wait_n = 0;
      got    = 1'b0;
      while (!got && wait_n < 20) begin
        tick();
        wait_n++;
        chk("rr_gap", 32'(tx_req & tx_end), 32'd0);
        if (gnt != 4'b0000) got = 1'b1;
      end
      chk("rr_grant_seen", 32'(got), 32'd1);
      chk("rr_gap_len", 32'(wait_n), 32'd2);
      chk("rr_gnt", 32'(gnt), 32'(4'b0001 << (t % 4)));
      chk("rr_sel", 32'(cur_sel), 32'(t % 4));
      for (int b = 0; b < 4; b++) begin
        dexp    = 16'(32'hB000 + t * 16 + b);
        src_st  = (b == 0) ? (4'b0001 << (t % 4)) : 4'b0000;
        src_end = (b == 3) ? (4'b0001 << (t % 4)) : 4'b0000;
        set_data(t % 4, dexp);
        tick();
        chk("rr_data", 32'(tx_data), 32'(dexp));
        chk("rr_strobe", 32'({tx_st, tx_end}), 32'({b == 0, b == 3}));
        chk("rr_gap", 32'(tx_req & tx_end), 32'd0);
      end
      src_st  = 4'b0000;
      src_end = 4'b0000;
    end

    // Source 1 streams while source 3 toggles strobes with 0xFFFF data.
    idle_inputs();
    req    = 4'b0010;
    tx_rdy = 1'b1;
    set_data(1, 16'h1234);
    set_data(3, 16'hFFFF);
    tick();
    chk("ns_req", 32'({tx_req, cur_sel}), 32'({1'b1, 2'd1}));
    tick();
    chk("ns_gnt", 32'(gnt), 32'h2);
    req     = 4'b0000;
    tx_rdy  = 1'b0;
    src_st  = 4'b1000;
    src_end = 4'b1000;
    tick();
    chk("ns_wait", 32'({tx_st, tx_end, busy}), 32'b001);
    chk("ns_wait_data", 32'(tx_data), 32'h1234);
    for (int b = 0; b < 5; b++) begin
      dexp    = 16'(32'hC000 + b);
      src_st  = ((b == 0) ? 4'b0010 : 4'b0000) | ((b % 2 == 0) ? 4'b1000 : 4'b0000);
      src_end = ((b == 4) ? 4'b0010 : 4'b0000) | ((b % 2 == 1) ? 4'b1000 : 4'b0000);
      set_data(1, dexp);
      tick();
      chk("ns_data", 32'(tx_data), 32'(dexp));
      chk("ns_strobe", 32'({tx_st, tx_end}), 32'({b == 0, b == 4}));
    end
    idle_inputs();
    tick();
    chk("ns_done", 32'(obs()), 32'(ov(1'b0, 4'b0000, 1'b0, 1'b0, 16'h0000, 1'b0, 2'd1)));

    // Source 0: src_st and src_end in the same beat (ptr is now 2, pick wraps to 0).
    req    = 4'b0001;
    tx_rdy = 1'b1;
    tick();
    chk("se_req", 32'({tx_req, cur_sel}), 32'({1'b1, 2'd0}));
    tick();
    chk("se_gnt", 32'(gnt), 32'h1);
    req     = 4'b0000;
    tx_rdy  = 1'b0;
    src_st  = 4'b0001;
    src_end = 4'b0001;
    set_data(0, 16'hD00D);
    tick();
    chk("se_beat", 32'(obs()), 32'(ov(1'b0, 4'b0000, 1'b1, 1'b1, 16'hD00D, 1'b0, 2'd0)));
    idle_inputs();
    tick();
    chk("se_after", 32'(obs()), 32'(ov(1'b0, 4'b0000, 1'b0, 1'b0, 16'h0000, 1'b0, 2'd0)));

    // Reset at beat 3 of a 10-beat TLP from source 3.
    req    = 4'b1000;
    tx_rdy = 1'b1;
    tick();
    tick();
    chk("rm_gnt", 32'(gnt), 32'h8);
    req    = 4'b0000;
    tx_rdy = 1'b0;
    for (int b = 0; b < 10; b++) begin
      dexp    = 16'(32'hE000 + b);
      src_st  = (b == 0) ? 4'b1000 : 4'b0000;
      src_end = (b == 9) ? 4'b1000 : 4'b0000;
      set_data(3, dexp);
      rst = (b == 3);
      tick();
      if (b < 3) begin
        chk("rm_data", 32'(tx_data), 32'(dexp));
      end else begin
        chk("rm_out", 32'(obs()), 32'd0);
      end
    end
    rst = 1'b0;
    idle_inputs();
    req    = 4'b0010;
    tx_rdy = 1'b1;
    tick();
    chk("rm_req1", 32'({tx_req, cur_sel, busy}), 32'({1'b1, 2'd1, 1'b1}));
    tick();
    chk("rm_gnt1", 32'(gnt), 32'h2);
    req     = 4'b0000;
    tx_rdy  = 1'b0;
    src_st  = 4'b0010;
    set_data(1, 16'hF000);
    tick();
    chk("rm_b0", 32'({tx_st, tx_end, tx_data}), 32'({1'b1, 1'b0, 16'hF000}));
    src_st  = 4'b0000;
    src_end = 4'b0010;
    set_data(1, 16'hF001);
    tick();
    chk("rm_b1", 32'({tx_st, tx_end, tx_data}), 32'({1'b0, 1'b1, 16'hF001}));
    idle_inputs();
    tick();

    // Source 0 granted but never starts; source 1 pending.
    do_reset();
    req    = 4'b0011;
    tx_rdy = 1'b1;
    tick();
    chk("wd_req", 32'({tx_req, cur_sel}), 32'({1'b1, 2'd0}));
    tick();
    chk("wd_gnt", 32'(gnt), 32'h1);
    req = 4'b0010;
`ifdef TX_ARB_WDOG_EN
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("wd_st", 32'(tx_st), 32'd0);
      chk("wd_err", 32'(err_timeout), 32'(i == 8));
      chk("wd_busy", 32'(busy), 32'(i != 8));
    end
    tick();
    chk("wd_next_req", 32'({tx_req, cur_sel, err_timeout}), 32'({1'b1, 2'd1, 1'b0}));
    tick();
    chk("wd_next_gnt", 32'(gnt), 32'h2);
    req     = 4'b0000;
    src_st  = 4'b0010;
    src_end = 4'b0010;
    tick();
    chk("wd_next_beat", 32'({tx_st, tx_end}), 32'b11);
    idle_inputs();
    tick();
`else
    for (int i = 1; i <= 20; i++) begin
      tick();
      chk("wd_hold_busy", 32'(busy), 32'd1);
      chk("wd_hold_err", 32'(err_timeout), 32'd0);
      chk("wd_hold_st", 32'(tx_st), 32'd0);
    end
    do_reset();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
